band_energy_meter: RTL and testbench

Downstream stage of the 8-band filter bank. It consumes the eight 16-bit band outputs on every sample strobe, squares and accumulates each band over a window of 2^WINLOG2 samples, and emits the mean power per band. Results leave as a serial stream of eight words under a valid/ready handshake, for the level-display and AGC logic. A single multiplier is shared across all bands by a small sequencer.

---
 rtl/band_energy_meter_if.sv | 32 +++
 rtl/band_energy_meter.sv | 195 +++++++++++++++++++
 tb/tb_band_energy_meter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/band_energy_meter_if.sv
// Result stream from band_energy_meter to the level-display / AGC logic.
//
// Handshake: the master raises power_valid with power/power_band and holds
// all three stable until a cycle in which power_ready is also high. A word
// transfers exactly on a rising clock edge where power_valid && power_ready.
// power_ready may be asserted independently of power_valid.
//
// Signals:
//   power        32  mean band power, unsigned (bit 31 is always zero)
//   power_band    3  band index of the word on power
//   power_valid   1  power / power_band are valid
//   power_ready   1  consumer accepts the current word
interface band_energy_meter_if;
  logic [31:0] power;
  logic [2:0]  power_band;
  logic        power_valid;
  logic        power_ready;

  modport master (
    output power,
    output power_band,
    output power_valid,
    input  power_ready
  );

  modport slave (
    input  power,
    input  power_band,
    input  power_valid,
    output power_ready
  );
endinterface

// File: rtl/band_energy_meter.sv
// band_energy_meter: squares and accumulates eight signed 16-bit filter-bank
// bands over a window of 2^WINLOG2 sample strobes, then streams out the
// floor mean power of each band as eight words (band 0..7).
//
// One squarer is time-shared: a strobe latches all eight bands into a
// capture register, and the sequencer then spends eight cycles (MAC state)
// squaring one band per cycle into its accumulator.
//
// Ports:
//   clock          in   master clock, rising edge
//   reset          in   asynchronous active-low reset
//   din_enable     in   one-cycle strobe, datain0..7 valid
//   datain0..7     in   signed 16-bit band samples
//   clear_overrun  in   synchronous clear of overrun, wins over a set
//   busy           out  sequencer is in MAC
//   overrun        out  sticky: strobe during MAC, or window end with full buffer
//   state_dbg      out  {state, band} of the sequencer
//   pwr            master side of the result stream
module band_energy_meter #(
  parameter int WINLOG2 = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                din_enable,
  input  logic signed [15:0]  datain0,
  input  logic signed [15:0]  datain1,
  input  logic signed [15:0]  datain2,
  input  logic signed [15:0]  datain3,
  input  logic signed [15:0]  datain4,
  input  logic signed [15:0]  datain5,
  input  logic signed [15:0]  datain6,
  input  logic signed [15:0]  datain7,
  input  logic                clear_overrun,
  output logic                busy,
  output logic                overrun,
  output logic [3:0]          state_dbg,
  band_energy_meter_if.master pwr
);

  // A 31-bit square summed 2^WINLOG2 times needs WINLOG2 extra bits.
  localparam int AW = 31 + WINLOG2;

  typedef enum logic {S_IDLE = 1'b0, S_MAC = 1'b1} state_t;

  state_t state, state_nx;
  logic [2:0] band, band_nx;
  logic       accept;
  logic       mac_en;

  logic signed [15:0] cap [8];
  logic [AW-1:0]      acc [8];
  logic [WINLOG2-1:0] sample_cnt;

  logic [30:0] obuf [8];
  logic        buf_full;
  logic [2:0]  out_idx;

  logic signed [15:0] cap_sel;
  logic [15:0]        mag;
  logic [30:0]        sq;
  logic [AW-1:0]      acc7_final;
  logic               last_band;
  logic               window_end;
  logic               xfer;

  // ---------------- sequencer ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      band  <= 3'd0;
    end else begin
      state <= state_nx;
      band  <= band_nx;
    end
  end

  always_comb begin
    state_nx = state;
    band_nx  = band;
    accept   = 1'b0;
    mac_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (din_enable) begin
          accept   = 1'b1;
          state_nx = S_MAC;
          band_nx  = 3'd0;
        end
      end
      S_MAC: begin
        mac_en  = 1'b1;
        band_nx = 3'(band + 3'd1);
        if (band == 3'd7) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------- squarer ----------------
  // Square via the magnitude so the product is natively unsigned; the
  // 16-bit magnitude of -32768 is 0x8000, whose square 2^30 fits 31 bits.
  assign cap_sel = cap[band];
  assign mag     = cap_sel[15] ? 16'(-cap_sel) : 16'(cap_sel);
  assign sq      = 31'(mag) * 31'(mag);

  assign last_band  = mac_en && (band == 3'd7);
  assign window_end = last_band && (sample_cnt == '1);
  // Band 7's final sum is formed in the same cycle as the buffer load.
  assign acc7_final = acc[7] + AW'(sq);

  // ---------------- capture / accumulate ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 8; k++) begin
        cap[k] <= '0;
        acc[k] <= '0;
      end
      sample_cnt <= '0;
    end else begin
      if (accept) begin
        cap[0] <= datain0;
        cap[1] <= datain1;
        cap[2] <= datain2;
        cap[3] <= datain3;
        cap[4] <= datain4;
        cap[5] <= datain5;
        cap[6] <= datain6;
        cap[7] <= datain7;
      end
      if (mac_en) begin
        if (window_end) begin
          for (int k = 0; k < 8; k++) begin
            acc[k] <= '0;
          end
        end else begin
          acc[band] <= acc[band] + AW'(sq);
        end
      end
      if (last_band) begin
        sample_cnt <= sample_cnt + WINLOG2'(1);
      end
    end
  end

  // ---------------- output buffer and dump ----------------
  assign xfer = buf_full && pwr.power_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 8; k++) begin
        obuf[k] <= '0;
      end
      buf_full <= 1'b0;
      out_idx  <= 3'd0;
    end else begin
      if (window_end && !buf_full) begin
        // Dropping the low WINLOG2 bits is the floor mean.
        for (int k = 0; k < 7; k++) begin
          obuf[k] <= acc[k][AW-1:WINLOG2];
        end
        obuf[7]  <= acc7_final[AW-1:WINLOG2];
        buf_full <= 1'b1;
        out_idx  <= 3'd0;
      end else if (xfer) begin
        if (out_idx == 3'd7) begin
          buf_full <= 1'b0;
          out_idx  <= 3'd0;
        end else begin
          out_idx <= 3'(out_idx + 3'd1);
        end
      end
    end
  end

  // ---------------- error flag ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end else if ((din_enable && state == S_MAC) || (window_end && buf_full)) begin
      overrun <= 1'b1;
    end
  end

  // power reads zero whenever no word is pending, so reset clears it at once.
  assign pwr.power       = buf_full ? {1'b0, obuf[out_idx]} : 32'd0;
  assign pwr.power_band  = out_idx;
  assign pwr.power_valid = buf_full;
  assign busy            = (state == S_MAC);
  assign state_dbg       = {state, band};

endmodule

// File: tb/tb_band_energy_meter.sv
// Self-checking bench for band_energy_meter (WINLOG2 = 2, four-sample windows).
// Directed windows push their hand-computed results into exp_q; a monitor
// pops and compares on every accepted output beat. Timing, backpressure,
// overrun and asynchronous reset are checked inline by the stimulus process.
module tb_band_energy_meter;

  logic               clock;
  logic               reset;
  logic               din_enable;
  logic               clear_overrun;
  logic signed [15:0] din [8];
  logic               busy;
  logic               overrun;
  logic [3:0]         state_dbg;

  band_energy_meter_if pwr_if ();

  band_energy_meter #(.WINLOG2(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .din_enable    (din_enable),
    .datain0       (din[0]),
    .datain1       (din[1]),
    .datain2       (din[2]),
    .datain3       (din[3]),
    .datain4       (din[4]),
    .datain5       (din[5]),
    .datain6       (din[6]),
    .datain7       (din[7]),
    .clear_overrun (clear_overrun),
    .busy          (busy),
    .overrun       (overrun),
    .state_dbg     (state_dbg),
    .pwr           (pwr_if)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  logic [34:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int beat_cnt = 0;

  // Hand-computed means: 4*(1000(k+1))^2 / 4 and 4*(10(k+1))^2 / 4.
  logic [31:0] exp_1000 [8] = '{32'd1000000, 32'd4000000, 32'd9000000, 32'd16000000,
                                32'd25000000, 32'd36000000, 32'd49000000, 32'd64000000};
  logic [31:0] exp_10 [8]   = '{32'd100, 32'd400, 32'd900, 32'd1600,
                                32'd2500, 32'd3600, 32'd4900, 32'd6400};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] b, input logic [31:0] v);
    exp_q.push_back({b, v});
  endtask

  task automatic push_all(input logic [31:0] v);
    for (int k = 0; k < 8; k++) push(3'(k), v);
  endtask

  // Monitor: compare every accepted beat against the queue head.
  always @(negedge clock) begin
    if (reset && pwr_if.power_valid && pwr_if.power_ready) begin
      logic [34:0] e;
      beat_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got band %0d power %0d with nothing expected",
                 pwr_if.power_band, pwr_if.power);
      end else begin
        e = exp_q.pop_front();
        check("beat_band", 64'(pwr_if.power_band), 64'(e[34:32]));
        check("beat_power", 64'(pwr_if.power), 64'(e[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic strobe();
    din_enable = 1'b1;
    tick(1);
    din_enable = 1'b0;
  endtask

  task automatic set_all(input logic signed [15:0] v);
    for (int k = 0; k < 8; k++) din[k] = v;
  endtask

  task automatic run_window();
    for (int i = 0; i < 4; i++) begin
      strobe();
      tick(11);
    end
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || pwr_if.power_valid) && cyc < 300) begin
      tick(1);
      cyc++;
    end
    check({name, "_left_in_queue"}, 64'(exp_q.size()), 64'd0);
    check({name, "_valid_low"}, 64'(pwr_if.power_valid), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    din_enable = 1'b0;
    clear_overrun = 1'b0;
    pwr_if.power_ready = 1'b1;
    set_all(16'sd0);
    #1;
    check("rst_power", 64'(pwr_if.power), 64'd0);
    check("rst_band", 64'(pwr_if.power_band), 64'd0);
    check("rst_valid", 64'(pwr_if.power_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    tick(3);
    reset = 1'b1;
    tick(2);

    // Constant input with exact latency checks on the last strobe.
    for (int k = 0; k < 8; k++) din[k] = 16'(1000 * (k + 1));
    for (int k = 0; k < 8; k++) push(3'(k), exp_1000[k]);
    beat_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      strobe();
      tick(11);
    end
    strobe();
    check("busy_after_strobe", 64'(busy), 64'd1);
    tick(7);
    check("valid_before_T9", 64'(pwr_if.power_valid), 64'd0);
    check("busy_band7", 64'(busy), 64'd1);
    tick(1);
    check("valid_at_T9", 64'(pwr_if.power_valid), 64'd1);
    check("band_at_T9", 64'(pwr_if.power_band), 64'd0);
    check("busy_done", 64'(busy), 64'd0);
    drain("const");
    check("const_beats", 64'(beat_cnt), 64'd8);

    // Extremes.
    set_all(-16'sd32768);
    push_all(32'h4000_0000);
    run_window();
    drain("neg_full_scale");
    set_all(16'sd0);
    push_all(32'd0);
    run_window();
    drain("zeros");

    // Alternating band 3.
    set_all(16'sd0);
    for (int k = 0; k < 8; k++) push(3'(k), (k == 3) ? 32'd10000 : 32'd0);
    for (int i = 0; i < 4; i++) begin
      din[3] = (i % 2 == 0) ? 16'sd100 : -16'sd100;
      strobe();
      tick(11);
    end
    drain("alternating");

    // Backpressure: held word must stay band 0 / 100.
    for (int k = 0; k < 8; k++) din[k] = 16'(10 * (k + 1));
    for (int k = 0; k < 8; k++) push(3'(k), exp_10[k]);
    pwr_if.power_ready = 1'b0;
    run_window();
    for (int i = 0; i < 20; i++) begin
      check("hold_valid", 64'(pwr_if.power_valid), 64'd1);
      check("hold_band", 64'(pwr_if.power_band), 64'd0);
      check("hold_power", 64'(pwr_if.power), 64'd100);
      tick(1);
    end
    check("hold_no_overrun", 64'(overrun), 64'd0);
    pwr_if.power_ready = 1'b1;
    drain("backpressure");

    // Strobes during MAC are ignored; clear_overrun wins over a set.
    set_all(16'sd1000);
    push_all(32'd1000000);
    strobe();
    tick(2);
    strobe();
    check("ovr_busy_strobe", 64'(overrun), 64'd1);
    clear_overrun = 1'b1;
    tick(1);
    clear_overrun = 1'b0;
    check("ovr_cleared", 64'(overrun), 64'd0);
    tick(7);
    strobe();
    tick(11);
    strobe();
    tick(2);
    clear_overrun = 1'b1;
    strobe();
    clear_overrun = 1'b0;
    check("ovr_clear_priority", 64'(overrun), 64'd0);
    tick(8);
    strobe();
    drain("ignored_strobes");

    // Second window completes while the first is still held.
    for (int k = 0; k < 8; k++) din[k] = 16'(10 * (k + 1));
    for (int k = 0; k < 8; k++) push(3'(k), exp_10[k]);
    pwr_if.power_ready = 1'b0;
    run_window();
    check("ovr_not_yet", 64'(overrun), 64'd0);
    set_all(16'sd20);
    run_window();
    check("ovr_full_buffer", 64'(overrun), 64'd1);
    check("ovr_held_band", 64'(pwr_if.power_band), 64'd0);
    check("ovr_held_power", 64'(pwr_if.power), 64'd100);
    pwr_if.power_ready = 1'b1;
    drain("full_buffer");
    clear_overrun = 1'b1;
    tick(1);
    clear_overrun = 1'b0;
    check("ovr_clear2", 64'(overrun), 64'd0);

    // Reset mid-MAC with a held word and overrun set.
    for (int k = 0; k < 8; k++) din[k] = 16'(10 * (k + 1));
    pwr_if.power_ready = 1'b0;
    run_window();
    strobe();
    tick(2);
    strobe();
    tick(1);
    check("pre_rst_busy", 64'(busy), 64'd1);
    check("pre_rst_valid", 64'(pwr_if.power_valid), 64'd1);
    check("pre_rst_overrun", 64'(overrun), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_power", 64'(pwr_if.power), 64'd0);
    check("async_rst_band", 64'(pwr_if.power_band), 64'd0);
    check("async_rst_valid", 64'(pwr_if.power_valid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_overrun", 64'(overrun), 64'd0);
    exp_q.delete();
    tick(2);
    reset = 1'b1;
    pwr_if.power_ready = 1'b1;
    tick(1);
    set_all(16'sd1000);
    push_all(32'd1000000);
    run_window();
    drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
